mod_segment_swapchain: RTL
==========================

MOD_SEGMENT_SWAPCHAIN -- requirements
Module: mod_segment_swapchain

Interface
REQ-001 Parameter: CYCLE_WIDTH, 15, width of sample index and cycle count.
REQ-002 CLK  in  1  system clock; all logic on rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 UPDATE  in  1  one-cycle pulse; new modulation settings valid this cycle.
REQ-005 REQ_RD_SEGMENT  in  1  requested segment (0/1), sampled with UPDATE.
REQ-006 TRANSITION_MODE  in  8  0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xFE IMMEDIATE, 0xFF EXT; sampled with UPDATE.
REQ-007 TRANSITION_VALUE  in  64  SYS_TIME target (mode 0x01) or GPIO pin select in bits [1:0] (mode 0x02); sampled with UPDATE.
REQ-008 REP0, REP1  in  16 each  loop count per segment; 0xFFFF = infinite; sampled with UPDATE.
REQ-009 IDX  in  CYCLE_WIDTH  current sample index of the active segment.
REQ-010 SYS_TIME  in  64  free-running system time.
REQ-011 GPIO_IN  in  4  external trigger inputs, already synchronised to CLK.
REQ-012 SEGMENT  out  1  active read segment.
REQ-013 STOP  out  1  high when the active segment has exhausted its loop count.
REQ-014 PENDING  out  1  high while an accepted request waits for its transition condition.

Function
REQ-015 States: IDLE (no request pending) and WAIT (request pending); reset state IDLE.
REQ-016 Wrap event: IDX==0 while the registered previous IDX!=0; the previous-IDX register resets to 0.
REQ-017 UPDATE with an undefined TRANSITION_MODE is ignored: no state, output or latched-field change.
REQ-018 UPDATE with a valid mode latches segment, mode, value and the REP of the requested segment into pending registers.
REQ-019 IMMEDIATE or EXT: SEGMENT takes the requested value on the cycle after UPDATE; state remains or returns to IDLE.
REQ-020 SYNC_IDX, SYS_TIME or GPIO: state goes to WAIT and PENDING=1 on the cycle after UPDATE.
REQ-021 In WAIT, switch condition: SYNC_IDX: wrap event; SYS_TIME: SYS_TIME >= latched value (unsigned 64-bit); GPIO: rising edge on GPIO_IN[value[1:0]].
REQ-022 Condition true in cycle N: SEGMENT updates, PENDING clears and state returns to IDLE at edge N+1.
REQ-023 The condition is not evaluated in the cycle in which UPDATE is accepted.
REQ-024 UPDATE in WAIT replaces the pending request entirely; the previous request never takes effect.
REQ-025 On every switch, including to the already-active segment: loop counter := 0, STOP := 0, active REP := latched REP.
REQ-026 Each wrap event in the active segment increments a 16-bit loop counter; the counter saturates at 0xFFFF.
REQ-027 When active REP != 0xFFFF and the wrap event brings the loop count to REP+1, STOP := 1 on the next edge.
REQ-028 STOP holds until the next switch, and SEGMENT is unchanged by STOP.
REQ-029 EXT only: when active REP != 0xFFFF, the STOP condition instead toggles SEGMENT, keeps STOP=0, and reloads REP from REP0/REP1 of the new segment as last latched.
REQ-030 A wrap event in the switch cycle counts toward the old segment only; the new segment counter starts at 0.
REQ-031 GPIO edge detector and previous-IDX register update every cycle, in both IDLE and WAIT.

Reset
REQ-032 RST outputs: SEGMENT=0, STOP=0, PENDING=0.
REQ-033 RST internal state: IDLE, loop counter 0, active REP 0xFFFF, pending fields 0, GPIO history 0.
REQ-034 RST asserted during WAIT discards the pending request.
REQ-035 RST has priority over UPDATE in the same cycle.

Verification
REQ-036 UPDATE, seg=1, mode 0xFE, REP1=0xFFFF -> SEGMENT=1 the next cycle; STOP stays 0 through 10 wraps.
REQ-037 UPDATE, seg=1, mode 0x00, with IDX counting 0..99 and currently at 50 -> PENDING=1; SEGMENT=1 one cycle after IDX returns to 0.
REQ-038 UPDATE mode 0x01, value=1000, SYS_TIME=990 incrementing by 1 -> SEGMENT changes at the edge after SYS_TIME=1000.
REQ-039 UPDATE mode 0x02, value=2 -> no switch on a GPIO_IN[1] pulse; switch one cycle after a GPIO_IN[2] rising edge.
REQ-040 mode 0xFF, seg=0, REP0=1, REP1=0 -> SEGMENT toggles 0->1 after 2 wraps, then 1->0 after 1 wrap; STOP stays 0.
REQ-041 mode 0xFE, REP=2 -> STOP=1 after 3rd wrap; mode 0x00 UPDATE, then RST in WAIT -> SEGMENT=0, PENDING=0, no later switch.

Source files
------------

// File: rtl/mod_segment_swapchain.sv
// rtl/mod_segment_swapchain.sv - double-buffered segment selector with timed swap and loop counting
module mod_segment_swapchain #(
  parameter int CYCLE_WIDTH = 15
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   UPDATE,
  input  logic                   REQ_RD_SEGMENT,
  input  logic [7:0]             TRANSITION_MODE,
  input  logic [63:0]            TRANSITION_VALUE,
  input  logic [15:0]            REP0,
  input  logic [15:0]            REP1,
  input  logic [CYCLE_WIDTH-1:0] IDX,
  input  logic [63:0]            SYS_TIME,
  input  logic [3:0]             GPIO_IN,
  output logic                   SEGMENT,
  output logic                   STOP,
  output logic                   PENDING
);

  localparam logic [7:0] MODE_SYNC_IDX  = 8'h00;
  localparam logic [7:0] MODE_SYS_TIME  = 8'h01;
  localparam logic [7:0] MODE_GPIO      = 8'h02;
  localparam logic [7:0] MODE_IMMEDIATE = 8'hFE;
  localparam logic [7:0] MODE_EXT       = 8'hFF;
  localparam logic [15:0] REP_INFINITE  = 16'hFFFF;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                 state_q, state_d;
  logic                   segment_q, segment_d;
  logic                   stop_q, stop_d;
  logic [CYCLE_WIDTH-1:0] idx_prev_q, idx_prev_d;
  logic [3:0]             gpio_prev_q, gpio_prev_d;
  logic [15:0]            loop_cnt_q, loop_cnt_d;
  logic [15:0]            rep_act_q, rep_act_d;
  logic                   act_ext_q, act_ext_d;
  logic                   pend_seg_q, pend_seg_d;
  logic [7:0]             pend_mode_q, pend_mode_d;
  logic [63:0]            pend_value_q, pend_value_d;
  logic [15:0]            pend_rep_q, pend_rep_d;
  logic [15:0]            lat_rep0_q, lat_rep0_d;
  logic [15:0]            lat_rep1_q, lat_rep1_d;

  logic        wrap, mode_valid, accept, accept_now, cond, cond_hit, gpio_rise;
  logic        sw, sw_seg, sw_ext, stop_hit;
  logic [15:0] sw_rep, req_rep, cnt_inc;

  // Next-state: request capture, switch decision and loop/STOP bookkeeping
  always_comb begin
    state_d      = state_q;
    segment_d    = segment_q;
    stop_d       = stop_q;
    idx_prev_d   = IDX;
    gpio_prev_d  = GPIO_IN;
    loop_cnt_d   = loop_cnt_q;
    rep_act_d    = rep_act_q;
    act_ext_d    = act_ext_q;
    pend_seg_d   = pend_seg_q;
    pend_mode_d  = pend_mode_q;
    pend_value_d = pend_value_q;
    pend_rep_d   = pend_rep_q;
    lat_rep0_d   = lat_rep0_q;
    lat_rep1_d   = lat_rep1_q;

    wrap       = (IDX == '0) && (idx_prev_q != '0);
    mode_valid = (TRANSITION_MODE == MODE_SYNC_IDX) || (TRANSITION_MODE == MODE_SYS_TIME) ||
                 (TRANSITION_MODE == MODE_GPIO) || (TRANSITION_MODE == MODE_IMMEDIATE) ||
                 (TRANSITION_MODE == MODE_EXT);
    accept     = UPDATE && mode_valid;
    accept_now = accept && ((TRANSITION_MODE == MODE_IMMEDIATE) || (TRANSITION_MODE == MODE_EXT));
    req_rep    = REQ_RD_SEGMENT ? REP1 : REP0;
    gpio_rise  = GPIO_IN[pend_value_q[1:0]] && !gpio_prev_q[pend_value_q[1:0]];

    case (pend_mode_q)
      MODE_SYNC_IDX: cond = wrap;
      MODE_SYS_TIME: cond = (SYS_TIME >= pend_value_q);
      MODE_GPIO:     cond = gpio_rise;
      default:       cond = 1'b0;
    endcase
    // A freshly accepted request always preempts evaluation of the old one
    cond_hit = (state_q == ST_WAIT) && !accept && cond;

    sw     = 1'b0;
    sw_seg = segment_q;
    sw_rep = rep_act_q;
    sw_ext = act_ext_q;

    if (accept) begin
      pend_seg_d   = REQ_RD_SEGMENT;
      pend_mode_d  = TRANSITION_MODE;
      pend_value_d = TRANSITION_VALUE;
      pend_rep_d   = req_rep;
      lat_rep0_d   = REP0;
      lat_rep1_d   = REP1;
      if (accept_now) begin
        state_d = ST_IDLE;
        sw      = 1'b1;
        sw_seg  = REQ_RD_SEGMENT;
        sw_rep  = req_rep;
        sw_ext  = (TRANSITION_MODE == MODE_EXT);
      end else begin
        state_d = ST_WAIT;
      end
    end else if (cond_hit) begin
      state_d = ST_IDLE;
      sw      = 1'b1;
      sw_seg  = pend_seg_q;
      sw_rep  = pend_rep_q;
      sw_ext  = 1'b0;
    end

    cnt_inc  = (loop_cnt_q == 16'hFFFF) ? loop_cnt_q : loop_cnt_q + 16'd1;
    stop_hit = wrap && (rep_act_q != REP_INFINITE) && (cnt_inc != loop_cnt_q) &&
               ({1'b0, cnt_inc} == ({1'b0, rep_act_q} + 17'd1));

    // A switch restarts counting; a wrap in the same cycle belongs to the old segment
    if (sw) begin
      segment_d  = sw_seg;
      rep_act_d  = sw_rep;
      act_ext_d  = sw_ext;
      loop_cnt_d = 16'd0;
      stop_d     = 1'b0;
    end else if (wrap) begin
      loop_cnt_d = cnt_inc;
      if (stop_hit) begin
        if (act_ext_q) begin
          segment_d  = !segment_q;
          rep_act_d  = segment_q ? lat_rep0_q : lat_rep1_q;
          loop_cnt_d = 16'd0;
        end else begin
          stop_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      segment_q    <= 1'b0;
      stop_q       <= 1'b0;
      idx_prev_q   <= '0;
      gpio_prev_q  <= 4'd0;
      loop_cnt_q   <= 16'd0;
      rep_act_q    <= REP_INFINITE;
      act_ext_q    <= 1'b0;
      pend_seg_q   <= 1'b0;
      pend_mode_q  <= 8'd0;
      pend_value_q <= 64'd0;
      pend_rep_q   <= 16'd0;
      lat_rep0_q   <= 16'd0;
      lat_rep1_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      segment_q    <= segment_d;
      stop_q       <= stop_d;
      idx_prev_q   <= idx_prev_d;
      gpio_prev_q  <= gpio_prev_d;
      loop_cnt_q   <= loop_cnt_d;
      rep_act_q    <= rep_act_d;
      act_ext_q    <= act_ext_d;
      pend_seg_q   <= pend_seg_d;
      pend_mode_q  <= pend_mode_d;
      pend_value_q <= pend_value_d;
      pend_rep_q   <= pend_rep_d;
      lat_rep0_q   <= lat_rep0_d;
      lat_rep1_q   <= lat_rep1_d;
    end
  end

  assign SEGMENT = segment_q;
  assign STOP    = stop_q;
  assign PENDING = (state_q == ST_WAIT);

endmodule
